// File: rtl/median_partition_stage.sv
// Purpose: one quickselect stage; partitions a frame around its pivot, then emits the result or forwards the selected partition.
// Latency: last pixel in -> DECIDE is 2 cycles; DECIDE -> first output strobe is 1 cycle.
// Backpressure: strobes gated by empty/full; the drain path uses a skid register, so out_px_full never loses or repeats a pixel.
module median_partition_stage #(
    parameter int DATA_W    = 8,
    parameter int BUFF_SIZE = 1024,
    parameter int SIZE_W    = $clog2(BUFF_SIZE) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_px,
    output logic              in_px_rd,
    input  logic              in_px_empty,
    input  logic [DATA_W-1:0] in_pivot,
    input  logic [SIZE_W-1:0] in_size,
    input  logic [SIZE_W-1:0] in_rank,
    output logic              in_hdr_rd,
    input  logic              in_hdr_empty,
    output logic [DATA_W-1:0] out_px,
    output logic              out_px_wr,
    input  logic              out_px_full,
    output logic [DATA_W-1:0] out_pivot,
    output logic [SIZE_W-1:0] out_size,
    output logic [SIZE_W-1:0] out_rank,
    output logic              out_hdr_wr,
    input  logic              out_hdr_full,
    output logic [DATA_W-1:0] out_result,
    output logic              out_result_wr,
    input  logic              out_result_full,
    output logic              err
);
    localparam int AW = $clog2(BUFF_SIZE);
    localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(BUFF_SIZE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HCAP   = 3'd1;
    localparam logic [2:0] S_FILL   = 3'd2;
    localparam logic [2:0] S_DECIDE = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;
    localparam logic [2:0] S_HDR    = 3'd5;
    localparam logic [2:0] S_DRAIN  = 3'd6;

    logic [2:0]        state;
    logic              live;       // low while reset is held so no strobe can leak out during reset
    logic [DATA_W-1:0] pivot;
    logic [SIZE_W-1:0] size, rank;
    logic [SIZE_W-1:0] cnt;        // reads issued (FILL) / memory reads issued (DRAIN)
    logic [SIZE_W-1:0] acc_cnt;    // pixels landed (FILL) / pixels written out (DRAIN)
    logic [SIZE_W-1:0] n_lo, n_hi, n_eq;
    logic [DATA_W-1:0] lo_min, lo_max, hi_min, hi_max;
    logic              px_vld;
    logic              sel_hi;

    logic [DATA_W-1:0] lo_mem [BUFF_SIZE];
    logic [DATA_W-1:0] hi_mem [BUFF_SIZE];
    logic [DATA_W-1:0] mem_q, skid;
    logic              mem_vld, skid_vld;
    logic              issue;

    logic              hdr_ok;
    logic              lo_sel, eq_sel, found;
    logic [DATA_W-1:0] sel_min, sel_max, found_val, new_pivot;
    logic [SIZE_W-1:0] sel_n, new_rank;
    logic [DATA_W:0]   mid_sum;

    assign in_hdr_rd     = live && (state == S_IDLE) && !in_hdr_empty;
    assign in_px_rd      = (state == S_FILL) && !in_px_empty && (cnt != size);
    assign out_result_wr = (state == S_RESULT) && !out_result_full;
    assign out_hdr_wr    = (state == S_HDR) && !out_hdr_full;
    assign out_px_wr     = (state == S_DRAIN) && (skid_vld || mem_vld) && !out_px_full;
    assign out_px        = skid_vld ? skid : mem_q;
    // Only fetch when the skid is free, so a stalled pixel always has a place to park.
    assign issue         = (state == S_DRAIN) && !skid_vld && (cnt != out_size);

    // Header validity and the partition decision, both pure functions of the current registers/inputs.
    always_comb begin
        hdr_ok    = (in_size != '0) && (in_size <= MAX_SIZE) && (in_rank < in_size);
        lo_sel    = rank < n_lo;
        eq_sel    = rank < (n_lo + n_eq);
        sel_min   = lo_sel ? lo_min : hi_min;
        sel_max   = lo_sel ? lo_max : hi_max;
        sel_n     = lo_sel ? n_lo : n_hi;
        new_rank  = lo_sel ? rank : (rank - n_lo - n_eq);
        found     = (!lo_sel && eq_sel) || (sel_min == sel_max);
        found_val = (!lo_sel && eq_sel) ? pivot : sel_min;
        mid_sum   = {1'b0, sel_min} + {1'b0, sel_max};
        new_pivot = mid_sum[DATA_W:1];
    end

    // Main control: header capture, fill/partition, decide, and output sequencing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            live       <= 1'b0;
            pivot      <= '0;
            size       <= '0;
            rank       <= '0;
            cnt        <= '0;
            acc_cnt    <= '0;
            n_lo       <= '0;
            n_hi       <= '0;
            n_eq       <= '0;
            lo_min     <= '0;
            lo_max     <= '0;
            hi_min     <= '0;
            hi_max     <= '0;
            px_vld     <= 1'b0;
            sel_hi     <= 1'b0;
            out_pivot  <= '0;
            out_size   <= '0;
            out_rank   <= '0;
            out_result <= '0;
            err        <= 1'b0;
        end else begin
            live   <= 1'b1;
            err    <= 1'b0;
            px_vld <= in_px_rd;
            case (state)
                S_IDLE: if (in_hdr_rd) state <= S_HCAP;
                S_HCAP: begin
                    pivot   <= in_pivot;
                    size    <= in_size;
                    rank    <= in_rank;
                    cnt     <= '0;
                    acc_cnt <= '0;
                    n_lo    <= '0;
                    n_hi    <= '0;
                    n_eq    <= '0;
                    if (hdr_ok) begin
                        state <= S_FILL;
                    end else begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_FILL: begin
                    if (in_px_rd) cnt <= cnt + 1'b1;
                    if (px_vld) begin
                        acc_cnt <= acc_cnt + 1'b1;
                        if (in_px < pivot) begin
                            n_lo <= n_lo + 1'b1;
                            if (n_lo == '0 || in_px < lo_min) lo_min <= in_px;
                            if (n_lo == '0 || in_px > lo_max) lo_max <= in_px;
                        end else if (in_px > pivot) begin
                            n_hi <= n_hi + 1'b1;
                            if (n_hi == '0 || in_px < hi_min) hi_min <= in_px;
                            if (n_hi == '0 || in_px > hi_max) hi_max <= in_px;
                        end else begin
                            n_eq <= n_eq + 1'b1;
                        end
                        if (acc_cnt == size - 1'b1) state <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    cnt     <= '0;
                    acc_cnt <= '0;
                    sel_hi  <= !lo_sel;
                    if (found) begin
                        out_result <= found_val;
                        state      <= S_RESULT;
                    end else begin
                        out_pivot <= new_pivot;
                        out_size  <= sel_n;
                        out_rank  <= new_rank;
                        state     <= S_HDR;
                    end
                end
                S_RESULT: if (out_result_wr) state <= S_IDLE;
                S_HDR:    if (out_hdr_wr) state <= S_DRAIN;
                S_DRAIN: begin
                    if (issue) cnt <= cnt + 1'b1;
                    if (out_px_wr) begin
                        acc_cnt <= acc_cnt + 1'b1;
                        if (acc_cnt == out_size - 1'b1) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Partition memories: arrival order is preserved by writing at the running count.
    always_ff @(posedge clock) begin
        if (state == S_FILL && px_vld) begin
            if (in_px < pivot)      lo_mem[n_lo[AW-1:0]] <= in_px;
            else if (in_px > pivot) hi_mem[n_hi[AW-1:0]] <= in_px;
        end
    end

    // Drain path: registered memory read plus a one-entry skid that absorbs a stalled read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q    <= '0;
            mem_vld  <= 1'b0;
            skid     <= '0;
            skid_vld <= 1'b0;
        end else begin
            if (issue) mem_q <= sel_hi ? hi_mem[cnt[AW-1:0]] : lo_mem[cnt[AW-1:0]];
            mem_vld <= issue || (mem_vld && skid_vld);
            if (skid_vld) begin
                skid_vld <= !out_px_wr;
            end else if (mem_vld && out_px_full) begin
                skid     <= mem_q;
                skid_vld <= 1'b1;
            end
        end
    end
endmodule
